// File: rtl/intr_ctrl.sv
// Interrupt controller: INTR edge detection, pending/enable gating, entry/exit sequencing, shadow C/Z.
// Optional INTR_SYNC_EN adds a 2-flop synchronizer in front of the edge detector.
module intr_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTR,
  input  logic       INSTR_DONE,
  input  logic       I_SET,
  input  logic       I_CLR,
  input  logic       RETIE,
  input  logic       C_IN,
  input  logic       Z_IN,
  output logic       INT_TAKEN,
  output logic       SHAD_LD,
  output logic       SHAD_C,
  output logic       SHAD_Z,
  output logic       FLG_RESTORE,
  output logic       I_EN,
  output logic       INT_ACTIVE,
  output logic       PENDING,
  output logic [7:0] INT_CNT
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StEnter  = 2'd1,
    StActive = 2'd2,
    StExit   = 2'd3
  } state_e;

  logic intr_s;

`ifdef INTR_SYNC_EN
  localparam int unsigned WarmLen = 3;
  logic [1:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[0], INTR};
  end

  assign intr_s = sync_q[1];
`else
  localparam int unsigned WarmLen = 1;

  assign intr_s = INTR;
`endif

  state_e             state_q;
  logic               prev_intr_q;
  logic [WarmLen-1:0] warm_q;
  logic               pending_q;
  logic               i_en_q;
  logic               shad_c_q;
  logic               shad_z_q;
  logic [7:0]         cnt_q;
  logic               taken_q;
  logic               restore_q;
  logic               active_q;
  logic               intr_edge;
  logic               enter_go;

  // A line already high when reset is released is not an edge; warm_q masks detection until
  // prev_intr_q holds a genuinely sampled value.
  assign intr_edge = intr_s & ~prev_intr_q & warm_q[WarmLen-1];
  assign enter_go  = (state_q == StIdle) & pending_q & i_en_q & INSTR_DONE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      prev_intr_q <= 1'b0;
      warm_q      <= '0;
      pending_q   <= 1'b0;
      i_en_q      <= 1'b0;
      shad_c_q    <= 1'b0;
      shad_z_q    <= 1'b0;
      cnt_q       <= 8'h00;
      taken_q     <= 1'b0;
      restore_q   <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      prev_intr_q <= intr_s;
      warm_q      <= (warm_q << 1) | WarmLen'(1);
      pending_q   <= intr_edge | (pending_q & ~enter_go);
      taken_q     <= 1'b0;
      restore_q   <= 1'b0;

      if (state_q == StExit) i_en_q <= 1'b1;
      else if (enter_go)     i_en_q <= 1'b0;
      else if (I_CLR)        i_en_q <= 1'b0;
      else if (I_SET)        i_en_q <= 1'b1;

      // Pulse outputs are registered from the next state so they never glitch.
      case (state_q)
        StIdle: begin
          if (enter_go) begin
            state_q  <= StEnter;
            taken_q  <= 1'b1;
            active_q <= 1'b1;
          end
        end
        StEnter: begin
          state_q  <= StActive;
          shad_c_q <= C_IN;
          shad_z_q <= Z_IN;
          if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end
        StActive: begin
          if (RETIE) begin
            state_q   <= StExit;
            restore_q <= 1'b1;
          end
        end
        StExit: begin
          state_q  <= StIdle;
          active_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign INT_TAKEN   = taken_q;
  assign SHAD_LD     = taken_q;
  assign SHAD_C      = shad_c_q;
  assign SHAD_Z      = shad_z_q;
  assign FLG_RESTORE = restore_q;
  assign I_EN        = i_en_q;
  assign INT_ACTIVE  = active_q;
  assign PENDING     = pending_q;
  assign INT_CNT     = cnt_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl (default build, no synchronizer).
module tb_intr_ctrl;

  logic       CLK, RST, INTR, INSTR_DONE, I_SET, I_CLR, RETIE, C_IN, Z_IN;
  logic       INT_TAKEN, SHAD_LD, SHAD_C, SHAD_Z, FLG_RESTORE, I_EN, INT_ACTIVE, PENDING;
  logic [7:0] INT_CNT;

  typedef struct packed {
    logic       c;
    logic       z;
    logic [7:0] cnt;
  } exp_t;

  exp_t       take_q[$];
  exp_t       restore_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_cnt = 8'h00;

  intr_ctrl dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .INSTR_DONE(INSTR_DONE), .I_SET(I_SET), .I_CLR(I_CLR),
    .RETIE(RETIE), .C_IN(C_IN), .Z_IN(Z_IN), .INT_TAKEN(INT_TAKEN), .SHAD_LD(SHAD_LD),
    .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z), .FLG_RESTORE(FLG_RESTORE), .I_EN(I_EN),
    .INT_ACTIVE(INT_ACTIVE), .PENDING(PENDING), .INT_CNT(INT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advances until INT_TAKEN is seen or the budget runs out (lat = -1).
  task automatic wait_taken(input int budget, output int lat);
    int n = 0;
    lat = -1;
    while (lat < 0 && n < budget) begin
      tick();
      n++;
      if (INT_TAKEN === 1'b1) lat = n;
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic test_reset();
    RST = 1'b1; INTR = 1'b1; I_SET = 1'b1; I_CLR = 1'b0; RETIE = 1'b0;
    INSTR_DONE = 1'b1; C_IN = 1'b0; Z_IN = 1'b0;
    repeat (3) tick();
    checks++;
    if ({INT_TAKEN, SHAD_LD, SHAD_C, SHAD_Z, FLG_RESTORE, I_EN, INT_ACTIVE, PENDING, INT_CNT}
        !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b_%h required all zero",
               {INT_TAKEN, SHAD_LD, SHAD_C, SHAD_Z, FLG_RESTORE, I_EN, INT_ACTIVE, PENDING},
               INT_CNT);
    end
    I_SET = 1'b0;
    RST = 1'b0;
    repeat (3) tick();
    checks++;
    if (PENDING !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_intr: PENDING=%b required 0", PENDING);
    end
    INTR = 1'b0;
    tick();
  endtask

  task automatic test_basic_entry();
    int   lat;
    exp_t e;
    I_SET = 1'b1; tick(); I_SET = 1'b0;
    checks++;
    if (I_EN !== 1'b1) begin errors++; $display("FAIL sei: I_EN=%b required 1", I_EN); end
    C_IN = 1'b1; Z_IN = 1'b0;
    model_cnt = sat_inc(model_cnt);
    take_q.push_back('{c: 1'b1, z: 1'b0, cnt: model_cnt});
    INTR = 1'b1;
    wait_taken(8, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL entry_latency: got %0d required 2", lat); end
    checks++;
    if (SHAD_LD !== 1'b1) begin errors++; $display("FAIL shad_ld: got %b required 1", SHAD_LD); end
    tick();
    INTR = 1'b0;
    checks++;
    if (INT_TAKEN !== 1'b0) begin
      errors++; $display("FAIL taken_pulse_width: got %b required 0", INT_TAKEN);
    end
    e = take_q.pop_front();
    checks++;
    if ({SHAD_C, SHAD_Z, INT_CNT} !== {e.c, e.z, e.cnt}) begin
      errors++;
      $display("FAIL entry_shadow: got c=%b z=%b cnt=%0d required c=%b z=%b cnt=%0d",
               SHAD_C, SHAD_Z, INT_CNT, e.c, e.z, e.cnt);
    end
    checks++;
    if ({I_EN, INT_ACTIVE} !== 2'b01) begin
      errors++; $display("FAIL entry_flags: I_EN=%b INT_ACTIVE=%b required 0 1", I_EN, INT_ACTIVE);
    end
  endtask

  task automatic test_exit();
    exp_t e;
    C_IN = 1'b0; Z_IN = 1'b1;
    tick();
    restore_q.push_back('{c: 1'b1, z: 1'b0, cnt: model_cnt});
    RETIE = 1'b1; tick(); RETIE = 1'b0;
    e = restore_q.pop_front();
    checks++;
    if ({FLG_RESTORE, SHAD_C, SHAD_Z} !== {1'b1, e.c, e.z}) begin
      errors++;
      $display("FAIL exit_restore: got fr=%b c=%b z=%b required fr=1 c=%b z=%b",
               FLG_RESTORE, SHAD_C, SHAD_Z, e.c, e.z);
    end
    tick();
    checks++;
    if ({FLG_RESTORE, I_EN, INT_ACTIVE} !== 3'b010) begin
      errors++;
      $display("FAIL exit_done: fr=%b I_EN=%b active=%b required 0 1 0",
               FLG_RESTORE, I_EN, INT_ACTIVE);
    end
    RETIE = 1'b1; tick(); RETIE = 1'b0; tick();
    checks++;
    if ({FLG_RESTORE, INT_ACTIVE, INT_TAKEN} !== 3'b000) begin
      errors++;
      $display("FAIL retie_idle: fr=%b active=%b taken=%b required 0 0 0",
               FLG_RESTORE, INT_ACTIVE, INT_TAKEN);
    end
  endtask

  task automatic test_masked();
    int   lat;
    int   seen = 0;
    exp_t e;
    I_CLR = 1'b1; tick(); I_CLR = 1'b0;
    INTR = 1'b1; tick();
    checks++;
    if ({PENDING, I_EN} !== 2'b10) begin
      errors++; $display("FAIL masked_pending: PENDING=%b I_EN=%b required 1 0", PENDING, I_EN);
    end
    INTR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (INT_TAKEN === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL masked_taken: got %0d pulses required 0", seen); end
    model_cnt = sat_inc(model_cnt);
    take_q.push_back('{c: C_IN, z: Z_IN, cnt: model_cnt});
    I_SET = 1'b1; tick(); I_SET = 1'b0;
    wait_taken(6, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL unmask_latency: got %0d required 1", lat); end
    tick();
    e = take_q.pop_front();
    checks++;
    if ({SHAD_C, SHAD_Z, INT_CNT} !== {e.c, e.z, e.cnt}) begin
      errors++;
      $display("FAIL unmask_shadow: got c=%b z=%b cnt=%0d required c=%b z=%b cnt=%0d",
               SHAD_C, SHAD_Z, INT_CNT, e.c, e.z, e.cnt);
    end
    RETIE = 1'b1; tick(); RETIE = 1'b0; tick();
  endtask

  task automatic test_no_nesting();
    int   lat;
    int   seen = 0;
    exp_t e;
    C_IN = 1'b1; Z_IN = 1'b1;
    model_cnt = sat_inc(model_cnt);
    take_q.push_back('{c: 1'b1, z: 1'b1, cnt: model_cnt});
    INTR = 1'b1;
    wait_taken(6, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL nest_first_latency: got %0d required 2", lat); end
    tick();
    e = take_q.pop_front();
    INTR = 1'b0; tick();
    INTR = 1'b1; tick();
    checks++;
    if (PENDING !== 1'b1) begin errors++; $display("FAIL nest_pending: got %b required 1", PENDING); end
    I_SET = 1'b1; tick(); I_SET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (INT_TAKEN === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL nested_taken: got %0d pulses required 0", seen); end
    model_cnt = sat_inc(model_cnt);
    take_q.push_back('{c: C_IN, z: Z_IN, cnt: model_cnt});
    RETIE = 1'b1; tick(); RETIE = 1'b0;
    wait_taken(6, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL back_to_back_latency: got %0d required 2", lat); end
    tick();
    e = take_q.pop_front();
    checks++;
    if (INT_CNT !== e.cnt) begin
      errors++; $display("FAIL reentry_count: got %0d required %0d", INT_CNT, e.cnt);
    end
    INTR = 1'b0; tick();
    INTR = 1'b1; tick();
    RST = 1'b1; #1;
    checks++;
    if ({INT_ACTIVE, PENDING, INT_CNT} !== 10'h000) begin
      errors++;
      $display("FAIL reset_in_isr: active=%b pending=%b cnt=%0d required 0 0 0",
               INT_ACTIVE, PENDING, INT_CNT);
    end
    model_cnt = 8'h00;
    INTR = 1'b0;
    tick(); tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    int   lat;
    exp_t e;
    I_SET = 1'b1; tick(); I_SET = 1'b0;
    for (int i = 0; i < 260; i++) begin
      C_IN = 1'($urandom_range(0, 1));
      Z_IN = 1'($urandom_range(0, 1));
      model_cnt = sat_inc(model_cnt);
      take_q.push_back('{c: C_IN, z: Z_IN, cnt: model_cnt});
      INTR = 1'b1;
      wait_taken(6, lat);
      tick();
      INTR = 1'b0;
      e = take_q.pop_front();
      checks++;
      if (lat < 0 || {SHAD_C, SHAD_Z, INT_CNT} !== {e.c, e.z, e.cnt}) begin
        errors++;
        $display("FAIL sat_iter%0d: lat=%0d c=%b z=%b cnt=%0d required c=%b z=%b cnt=%0d",
                 i, lat, SHAD_C, SHAD_Z, INT_CNT, e.c, e.z, e.cnt);
      end
      RETIE = 1'b1; tick(); RETIE = 1'b0; tick();
    end
    checks++;
    if (INT_CNT !== 8'hFF) begin errors++; $display("FAIL saturate: got %h required ff", INT_CNT); end
  endtask

  task automatic test_conflict();
    checks++;
    if (I_EN !== 1'b1) begin errors++; $display("FAIL conflict_pre: I_EN=%b required 1", I_EN); end
    I_SET = 1'b1; I_CLR = 1'b1; tick(); I_SET = 1'b0; I_CLR = 1'b0;
    checks++;
    if (I_EN !== 1'b0) begin errors++; $display("FAIL set_clr_conflict: I_EN=%b required 0", I_EN); end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_exit();
    test_masked();
    test_no_nesting();
    test_saturation();
    test_conflict();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
